cram_backup_ctrl: RTL and testbench
===================================

# cram_backup_ctrl

Arbiter and sequencer for the cartridge save RAM. It shares the single-port cart RAM between the CPU path (cart RAM address and data from the active mapper) and the battery save-file transfer to and from the bridge. The transfer is a byte-serial dump (save) or fill (load). It sits between the mapper mux and the cart RAM and also reports a dirty flag for autosave.

## Interface
Parameters:
- ADDR_W, 17, cart RAM byte-address width (128 KiB max)

Ports:
- clk_sys  in  1  system clock; every register in this block is on this one clock
- reset  in  1  synchronous, active-high reset
- ce_cpu  in  1  CPU clock enable; marks a CPU-owned RAM slot
- cpu_addr  in  ADDR_W  CPU cart RAM address (from mapper cram_addr)
- cpu_wr  in  1  CPU write strobe (already qualified by mapper ram_enabled)
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data
- ram_addr  out  ADDR_W  cart RAM address
- ram_wr  out  1  cart RAM write enable
- ram_di  out  8  cart RAM write data
- ram_do  in  8  cart RAM read data, registered, valid 1 cycle after ram_addr
- save_req  in  1  pulse: start dump of save_size bytes
- load_req  in  1  pulse: start fill of save_size bytes
- save_size  in  ADDR_W+1  transfer length in bytes (0 … 2^ADDR_W)
- dump_data  out  8  dump byte to bridge
- dump_valid  out  1  dump_data valid
- dump_ready  in  1  bridge accepts dump byte
- load_data  in  8  fill byte from bridge
- load_valid  in  1  load_data valid
- load_ready  out  1  block accepts fill byte
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- dirty  out  1  CPU wrote cart RAM since last dump start

## Operation
- Slot arbitration: when ce_cpu=1, the CPU owns the RAM. In that cycle ram_addr=cpu_addr, ram_wr=cpu_wr and ram_di=cpu_di. When ce_cpu=0, the engine may drive the RAM. Otherwise ram_addr=cpu_addr and ram_wr=0.
- cpu_do=ram_do, passed through combinationally at all times.
- The engine never writes or issues a read in a ce_cpu=1 cycle. The CPU is never stalled.
- State machine:
  - IDLE: a request starts a transfer. save_req goes to DUMP_RD and load_req goes to LOAD_WAIT. Both load the address counter with 0 and the remaining count with save_size. If both requests arrive in the same cycle, save wins and load is dropped. If save_size=0, the FSM goes straight to DONE.
  - DUMP_RD: waits for ce_cpu=0, then drives ram_addr=counter (read) and moves to DUMP_CAP.
  - DUMP_CAP: captures ram_do into dump_data, sets dump_valid and moves to DUMP_OUT. It captures even if this cycle is a CPU slot, because ram_do still reflects the engine address from the previous cycle.
  - DUMP_OUT: holds dump_valid and dump_data stable until dump_ready. On the handshake, dump_valid is cleared, the counter is incremented and the remaining count is decremented. If the remaining count reaches 0 the FSM goes to DONE, otherwise to DUMP_RD.
  - LOAD_WAIT: load_ready=1. On load_valid&load_ready the byte is latched, load_ready is cleared and the FSM goes to LOAD_WR.
  - LOAD_WR: waits for ce_cpu=0, then issues ram_wr=1, ram_addr=counter and ram_di=latched byte for one cycle. It then increments and decrements. If the remaining count reaches 0 the FSM goes to DONE, otherwise to LOAD_WAIT.
  - DONE: pulses done for 1 cycle and returns to IDLE.
- busy=1 in every state except IDLE. save_req and load_req are ignored while busy.
- dirty:
  - Set on any cycle with ce_cpu&cpu_wr.
  - Cleared in the cycle a dump is accepted from IDLE.
  - If a CPU write and a dump start happen in the same cycle, dirty stays set.
  - A load start does not change dirty.
- CPU writes during a dump are allowed. A byte may be dumped before or after the write; the only guarantee is that dirty ends up set.
- Counter arithmetic: the address is ADDR_W wide and the remaining count is ADDR_W+1 wide. With save_size=2^ADDR_W, the address wraps to 0 exactly when the count reaches 0. No extra access is issued.

## Timing
- Reset values: dump_valid=0, load_ready=0, busy=0, done=0, dirty=0, dump_data=0, ram_wr=0. State=IDLE and counters=0.
- Reset mid-transfer aborts the transfer with no done pulse and no further RAM writes. The bridge must re-request.
- Request to first engine RAM access: 1 cycle (IDLE→DUMP_RD), plus however many ce_cpu=1 cycles occur.
- Dump, with ce_cpu=0 and dump_ready=1 throughout:
  - Read issue to dump_valid: 2 cycles.
  - Sustained throughput: 1 byte per 3 cycles.
- Load: load handshake to RAM write takes ≥1 cycle. Best case is 1 byte per 2 cycles.
- dump_data must not change while dump_valid=1 and dump_ready=0.
- done is asserted in the cycle after the last handshake or write. busy falls in the cycle after done.

## Test plan
- Dump: preload RAM[0..3]=11,22,33,44, save_size=4, dump_ready=1, ce_cpu=0. Require dump bytes 11,22,33,44 in order, then exactly one done pulse, then busy=0.
- Load with CPU contention: save_size=3, fill bytes A1,B2,C3, ce_cpu toggling every cycle. Require RAM[0..2]=A1,B2,C3, zero engine writes in ce_cpu=1 cycles, and unchanged CPU writes landing at cpu_addr.
- Backpressure: dump with dump_ready low for 5 cycles on byte 2. Require dump_data held stable, no skipped or duplicated bytes, and address advancing only on the handshake.
- Simultaneous requests and size 0: save_req=load_req=1 together runs a dump only. save_size=0 gives done 1 cycle after the request with no RAM access.
- Dirty: a CPU write at 0x0100 sets dirty=1. A dump start clears it. A CPU write during the dump sets it again. A load leaves it unchanged.
- Reset mid-dump after 2 of 8 bytes: all outputs return to reset values next cycle, with no done pulse. A subsequent save_req restarts at address 0.

Source files
------------

// File: rtl/cram_backup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cram_backup_ctrl                                                |
// | Purpose  : Cart save-RAM slot arbiter plus byte-serial save dump/load      |
// |            sequencer, with a CPU-write dirty flag for autosave.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cram_backup_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_cpu,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_do,
    input  logic              save_req,
    input  logic              load_req,
    input  logic [ADDR_W:0]   save_size,
    output logic [7:0]        dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              busy,
    output logic              done,
    output logic              dirty
);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_DUMP_RD   = 3'd1;
    localparam logic [2:0] c_S_DUMP_CAP  = 3'd2;
    localparam logic [2:0] c_S_DUMP_OUT  = 3'd3;
    localparam logic [2:0] c_S_LOAD_WAIT = 3'd4;
    localparam logic [2:0] c_S_LOAD_WR   = 3'd5;
    localparam logic [2:0] c_S_DONE      = 3'd6;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic [7:0]        r_dump_data;
    logic [7:0]        r_load_byte;
    logic              r_dump_valid;
    logic              r_load_ready;
    logic              r_done;
    logic              r_dirty;

    logic w_cpu_write;
    logic w_eng_rd;
    logic w_eng_wr;
    logic w_last;
    logic w_size_zero;
    logic w_dump_start;

    assign w_cpu_write  = ce_cpu & cpu_wr;
    assign w_eng_rd     = (r_state == c_S_DUMP_RD) & ~ce_cpu;
    // Gating with reset keeps an aborted load from landing one last byte.
    assign w_eng_wr     = (r_state == c_S_LOAD_WR) & ~ce_cpu & ~reset;
    assign w_last       = (r_remain == c_CNT_ONE);
    assign w_size_zero  = (save_size == '0);
    assign w_dump_start = (r_state == c_S_IDLE) & save_req;

    always_comb begin
        ram_addr = cpu_addr;
        ram_wr   = 1'b0;
        ram_di   = cpu_di;
        if (ce_cpu) begin
            ram_wr = cpu_wr;
        end else if (w_eng_rd) begin
            ram_addr = r_addr;
        end else if (w_eng_wr) begin
            ram_addr = r_addr;
            ram_wr   = 1'b1;
            ram_di   = r_load_byte;
        end
    end

    assign cpu_do     = ram_do;
    assign dump_data  = r_dump_data;
    assign dump_valid = r_dump_valid;
    assign load_ready = r_load_ready;
    assign busy       = (r_state != c_S_IDLE);
    assign done       = r_done;
    assign dirty      = r_dirty;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_dump_data  <= '0;
            r_load_byte  <= '0;
            r_dump_valid <= 1'b0;
            r_load_ready <= 1'b0;
            r_done       <= 1'b0;
            r_dirty      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A CPU write in the same cycle as a dump start wins: the data may miss the dump.
            if (w_cpu_write) begin
                r_dirty <= 1'b1;
            end else if (w_dump_start) begin
                r_dirty <= 1'b0;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (save_req || load_req) begin
                        r_addr   <= '0;
                        r_remain <= save_size;
                        if (w_size_zero) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end else if (save_req) begin
                            r_state <= c_S_DUMP_RD;
                        end else begin
                            r_state      <= c_S_LOAD_WAIT;
                            r_load_ready <= 1'b1;
                        end
                    end
                end

                c_S_DUMP_RD: begin
                    if (!ce_cpu) begin
                        r_state <= c_S_DUMP_CAP;
                    end
                end

                // ram_do still belongs to the engine's read even if this is a CPU slot.
                c_S_DUMP_CAP: begin
                    r_dump_data  <= ram_do;
                    r_dump_valid <= 1'b1;
                    r_state      <= c_S_DUMP_OUT;
                end

                c_S_DUMP_OUT: begin
                    if (r_dump_valid && dump_ready) begin
                        r_dump_valid <= 1'b0;
                        r_addr       <= r_addr + c_ADDR_ONE;
                        r_remain     <= r_remain - c_CNT_ONE;
                        if (w_last) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_S_DUMP_RD;
                        end
                    end
                end

                c_S_LOAD_WAIT: begin
                    if (load_valid && r_load_ready) begin
                        r_load_byte  <= load_data;
                        r_load_ready <= 1'b0;
                        r_state      <= c_S_LOAD_WR;
                    end
                end

                c_S_LOAD_WR: begin
                    if (!ce_cpu) begin
                        r_addr   <= r_addr + c_ADDR_ONE;
                        r_remain <= r_remain - c_CNT_ONE;
                        if (w_last) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= c_S_LOAD_WAIT;
                            r_load_ready <= 1'b1;
                        end
                    end
                end

                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end

                default: begin
                    r_state      <= c_S_IDLE;
                    r_dump_valid <= 1'b0;
                    r_load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cram_backup_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_cram_backup_ctrl                                             |
// | Purpose  : Self-checking bench for cram_backup_ctrl with a RAM model and   |
// |            a byte-level reference of memory contents and the dirty flag.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cram_backup_ctrl;

    localparam int AW    = 9;
    localparam int SW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ce_cpu;
    logic [AW-1:0] cpu_addr;
    logic          cpu_wr;
    logic [7:0]    cpu_di;
    logic [7:0]    cpu_do;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [7:0]    ram_di;
    logic [7:0]    ram_do;
    logic          save_req;
    logic          load_req;
    logic [SW-1:0] save_size;
    logic [7:0]    dump_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [7:0]    load_data;
    logic          load_valid;
    logic          load_ready;
    logic          busy;
    logic          done;
    logic          dirty;

    always #5 clk_sys = ~clk_sys;

    cram_backup_ctrl #(.ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .cpu_addr(cpu_addr),
        .cpu_wr(cpu_wr), .cpu_di(cpu_di), .cpu_do(cpu_do), .ram_addr(ram_addr),
        .ram_wr(ram_wr), .ram_di(ram_di), .ram_do(ram_do), .save_req(save_req),
        .load_req(load_req), .save_size(save_size), .dump_data(dump_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .load_data(load_data),
        .load_valid(load_valid), .load_ready(load_ready), .busy(busy),
        .done(done), .dirty(dirty)
    );

    // Single-port cart RAM with a registered read port.
    logic [7:0] mem [0:DEPTH-1];
    always @(posedge clk_sys) begin
        if (ram_wr) mem[ram_addr] <= ram_di;
        ram_do <= mem[ram_addr];
    end

    logic [7:0] exp_mem [0:DEPTH-1];
    logic [7:0] fill_q [$];
    bit         exp_dirty;
    bit         model_busy;
    int         n_cmp;
    int         n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and fold the applied inputs into the reference state.
    task automatic cycle();
        @(posedge clk_sys);
        if (ce_cpu && cpu_wr) exp_mem[cpu_addr] = cpu_di;
        if (reset) begin
            exp_dirty  = 1'b0;
            model_busy = 1'b0;
        end else if (ce_cpu && cpu_wr) begin
            exp_dirty = 1'b1;
        end else if (save_req && !model_busy) begin
            exp_dirty = 1'b0;
        end
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
        if (ce_cpu)
            chk("cpu_slot", 32'({ram_addr, ram_wr, ram_di}), 32'({cpu_addr, cpu_wr, cpu_di}));
        chk("cpu_do", 32'(cpu_do), 32'(ram_do));
        chk("dirty", 32'(dirty), 32'(exp_dirty));
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        ce_cpu = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_di = d;
        sample();
        cycle();
        ce_cpu = 1'b0; cpu_wr = 1'b0;
    endtask

    function automatic logic pick_ce(input int mode, input logic prev);
        if (mode == 0) return 1'b0;
        if (mode == 1) return ~prev;
        return $urandom_range(1) == 1;
    endfunction

    function automatic logic [AW-1:0] rand_hi(input int lo);
        if (lo >= DEPTH) return '0;
        return AW'(lo + int'($urandom_range(DEPTH - 1 - lo)));
    endfunction

    task automatic rand_fill(input int size);
        fill_q.delete();
        for (int i = 0; i < size; i++) fill_q.push_back(8'($urandom));
    endtask

    task automatic do_dump(input int size, input int ce_mode, input int rdy_pct, input bit wr_mix,
                           input bit start_wr, input bit with_load, input int stall_byte);
        logic [7:0] got [$];
        int  cyc, done_cnt, done_cyc, fin_cyc, first_vld, eng_rd, eng_wr, nbad, stalls;
        bit  hold;
        logic [7:0] hold_d;
        bit  track;
        track = (size < DEPTH);
        cyc = 0; done_cnt = 0; done_cyc = -1; fin_cyc = -1; first_vld = -1;
        eng_rd = 0; eng_wr = 0; nbad = 0; stalls = 0; hold = 1'b0; hold_d = '0;
        save_req = 1'b1; load_req = with_load; save_size = SW'(size);
        ce_cpu = start_wr; cpu_wr = start_wr; cpu_addr = AW'(DEPTH - 1); cpu_di = 8'($urandom);
        dump_ready = 1'b0;
        sample();
        cycle();
        save_req = 1'b0; load_req = 1'b0; model_busy = 1'b1;
        while (fin_cyc < 0 && cyc < 40 * size + 40) begin
            cyc++;
            ce_cpu   = pick_ce(ce_mode, ce_cpu);
            cpu_wr   = ce_cpu && wr_mix && track && ($urandom_range(1) == 1);
            cpu_addr = track ? rand_hi(size) : '0;
            cpu_di   = 8'($urandom);
            if (stall_byte >= 0) dump_ready = !(got.size() == stall_byte && stalls < 5);
            else                 dump_ready = ($urandom_range(99) < rdy_pct);
            sample();
            if (hold) chk("dump_hold", 32'({dump_valid, dump_data}), 32'({1'b1, hold_d}));
            chk("load_ready_in_dump", 32'(load_ready), 32'(0));
            if (track && !ce_cpu && (ram_wr || ram_addr != cpu_addr)) begin
                if (ram_wr) eng_wr++;
                else begin
                    chk("dump_rd_addr", 32'(ram_addr), 32'(eng_rd));
                    eng_rd++;
                end
            end
            if (dump_valid && first_vld < 0) first_vld = cyc;
            if (dump_valid && dump_ready) got.push_back(dump_data);
            if (dump_valid && !dump_ready) stalls++;
            hold = dump_valid && !dump_ready;
            hold_d = dump_data;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!busy) fin_cyc = cyc;
            cycle();
        end
        ce_cpu = 1'b0; cpu_wr = 1'b0; dump_ready = 1'b0; model_busy = 1'b0;
        chk("dump_finished", 32'(fin_cyc >= 0), 32'(1));
        chk("dump_count", 32'(got.size()), 32'(size));
        for (int i = 0; i < got.size() && i < size; i++)
            if (got[i] !== exp_mem[i]) nbad++;
        chk("dump_bytes_bad", 32'(nbad), 32'(0));
        chk("dump_done_pulses", 32'(done_cnt), 32'(1));
        chk("dump_busy_after_done", 32'(fin_cyc), 32'(done_cyc + 1));
        if (track) begin
            chk("dump_reads", 32'(eng_rd), 32'(size));
            chk("dump_writes", 32'(eng_wr), 32'(0));
        end
        if (stall_byte >= 0) chk("dump_stalls", 32'(stalls), 32'(5));
        if (ce_mode == 0 && rdy_pct >= 100 && stall_byte < 0) begin
            chk("dump_done_latency", 32'(done_cyc), 32'(3 * size + 1));
            if (size > 0) chk("dump_first_valid", 32'(first_vld), 32'(3));
        end
    endtask

    task automatic do_load(input int size, input int ce_mode, input int vld_pct, input bit wr_mix,
                           input bit poke_req);
        int idx, eng_wr, cyc, done_cnt, done_cyc, fin_cyc, nbad;
        idx = 0; eng_wr = 0; cyc = 0; done_cnt = 0; done_cyc = -1; fin_cyc = -1; nbad = 0;
        load_req = 1'b1; save_size = SW'(size); ce_cpu = 1'b0; cpu_wr = 1'b0; load_valid = 1'b0;
        sample();
        cycle();
        load_req = 1'b0; model_busy = 1'b1;
        while (fin_cyc < 0 && cyc < 40 * size + 40) begin
            cyc++;
            ce_cpu     = pick_ce(ce_mode, ce_cpu);
            cpu_wr     = ce_cpu && wr_mix && ($urandom_range(1) == 1);
            cpu_addr   = rand_hi(size);
            cpu_di     = 8'($urandom);
            save_req   = poke_req && (cyc == 3);
            load_req   = poke_req && (cyc == 5);
            load_valid = (idx < size) && ($urandom_range(99) < vld_pct);
            load_data  = (idx < size) ? fill_q[idx] : 8'($urandom);
            sample();
            if (!ce_cpu && ram_wr) begin
                chk("load_wr_addr", 32'(ram_addr), 32'(eng_wr));
                if (eng_wr < size) chk("load_wr_data", 32'(ram_di), 32'(fill_q[eng_wr]));
                eng_wr++;
            end
            if (load_valid && load_ready) idx++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (!busy) fin_cyc = cyc;
            cycle();
        end
        save_req = 1'b0; load_req = 1'b0; load_valid = 1'b0;
        ce_cpu = 1'b0; cpu_wr = 1'b0; model_busy = 1'b0;
        for (int i = 0; i < size; i++) exp_mem[i] = fill_q[i];
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) nbad++;
        chk("load_finished", 32'(fin_cyc >= 0), 32'(1));
        chk("load_ram_bad", 32'(nbad), 32'(0));
        chk("load_accepted", 32'(idx), 32'(size));
        chk("load_writes", 32'(eng_wr), 32'(size));
        chk("load_done_pulses", 32'(done_cnt), 32'(1));
        chk("load_busy_after_done", 32'(fin_cyc), 32'(done_cyc + 1));
        if (ce_mode == 0 && vld_pct >= 100)
            chk("load_done_latency", 32'(done_cyc), 32'(2 * size + 1));
    endtask

    initial begin
        int n, sz, cm;
        n_cmp = 0; n_bad = 0; exp_dirty = 1'b0; model_busy = 1'b0;
        reset = 1'b1; ce_cpu = 1'b0; cpu_addr = '0; cpu_wr = 1'b0; cpu_di = '0;
        save_req = 1'b0; load_req = 1'b0; save_size = '0; dump_ready = 1'b0;
        load_data = '0; load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;

        sample();
        chk("rst_dump_valid", 32'(dump_valid), 32'(0));
        chk("rst_load_ready", 32'(load_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_dump_data", 32'(dump_data), 32'(0));
        chk("rst_ram_wr", 32'(ram_wr), 32'(0));
        cycle();

        for (int i = 0; i < DEPTH; i++) cpu_write(AW'(i), 8'($urandom));
        cpu_write(AW'(0), 8'h11);
        cpu_write(AW'(1), 8'h22);
        cpu_write(AW'(2), 8'h33);
        cpu_write(AW'(3), 8'h44);

        // Directed dump of the four known bytes, then dirty bookkeeping.
        do_dump(4, 0, 100, 1'b0, 1'b0, 1'b0, -1);
        cpu_write(AW'(9'h100), 8'h5A);
        do_dump(8, 0, 100, 1'b0, 1'b0, 1'b0, 2);
        do_dump(6, 2, 70, 1'b1, 1'b0, 1'b0, -1);

        cpu_write(AW'(9'h100), 8'hC7);
        rand_fill(5);
        do_load(5, 0, 100, 1'b0, 1'b0);
        fill_q = '{8'hA1, 8'hB2, 8'hC3};
        do_load(3, 1, 100, 1'b1, 1'b0);
        do_dump(0, 0, 100, 1'b0, 1'b0, 1'b0, -1);
        rand_fill(4);
        do_load(4, 0, 60, 1'b0, 1'b0);

        do_dump(5, 0, 100, 1'b0, 1'b0, 1'b1, -1);
        rand_fill(0);
        do_load(0, 0, 100, 1'b0, 1'b0);
        do_dump(3, 0, 100, 1'b0, 1'b1, 1'b0, -1);
        rand_fill(6);
        do_load(6, 1, 80, 1'b1, 1'b1);
        do_dump(DEPTH, 0, 100, 1'b0, 1'b0, 1'b0, -1);
        do_dump(4, 2, 80, 1'b1, 1'b0, 1'b0, -1);

        // Reset in the middle of an 8-byte dump, with byte 2 presented.
        save_req = 1'b1; save_size = SW'(8); ce_cpu = 1'b0; cpu_wr = 1'b0; dump_ready = 1'b1;
        cpu_addr = AW'(DEPTH - 1);
        cycle();
        save_req = 1'b0; model_busy = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            sample();
            if (dump_valid && dump_ready) n++;
            cycle();
        end
        chk("pre_reset_handshakes", 32'(n), 32'(2));
        dump_ready = 1'b0;
        sample(); cycle();
        sample(); cycle();
        reset = 1'b1;
        sample();
        chk("pre_reset_valid", 32'({dump_valid, dump_data}), 32'({1'b1, exp_mem[2]}));
        cycle();
        reset = 1'b0;
        sample();
        chk("abort_outputs", 32'({dump_valid, load_ready, busy, done, dirty, ram_wr}), 32'(0));
        chk("abort_dump_data", 32'(dump_data), 32'(0));
        cycle();
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("abort_quiet", 32'({done, busy, ram_wr}), 32'(0));
            cycle();
        end
        do_dump(8, 0, 100, 1'b0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            sz = $urandom_range(24, 1);
            cm = $urandom_range(2);
            if ($urandom_range(1) == 1) begin
                do_dump(sz, cm, $urandom_range(100, 30), 1'b1, 1'b0, 1'b0, -1);
            end else begin
                rand_fill(sz);
                do_load(sz, cm, $urandom_range(100, 30), 1'b1, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
